// File: rtl/pulse_shaper.sv
// Turns single-cycle event strobes into levels: toggle, one-shot (plain or retriggerable) or blink train.
// Define PULSE_SHAPER_SYNC_EN to treat pulse_in as an asynchronous level (2-FF synchronizer + rising-edge detect).
module pulse_shaper #(
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic [1:0] select_mode,
  output logic       level_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_BLINK
  } state_e;

  localparam logic [1:0] MODE_TOGGLE  = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_RETRIG  = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic ev;

`ifdef PULSE_SHAPER_SYNC_EN
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign ev = sync2_q & ~prev_q;
`else
  assign ev = pulse_in;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q;
  logic             level_q, level_d;
  logic             toggle_q, toggle_d;
  logic             busy_q, done_q, done_d;
  logic             mode_change;

  assign mode_change = (select_mode != mode_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    toggle_d = toggle_q;
    done_d   = 1'b0;

    if (mode_change) begin
      // A mode switch wipes everything and swallows any event on the same cycle.
      state_d  = ST_IDLE;
      cnt_d    = '0;
      level_d  = 1'b0;
      toggle_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ev) begin
            unique case (mode_q)
              MODE_TOGGLE: begin
                toggle_d = ~toggle_q;
                level_d  = ~toggle_q;
              end
              MODE_ONESHOT, MODE_RETRIG: begin
                state_d = ST_HOLD;
                cnt_d   = RELOAD;
                level_d = 1'b1;
              end
              MODE_BLINK: begin
                state_d = ST_BLINK;
                cnt_d   = RELOAD;
                level_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_HOLD: begin
          if (ev && mode_q == MODE_RETRIG) begin
            cnt_d = RELOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
            level_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_BLINK: begin
          // A stop event wins over a coincident half-period expiry.
          if (ev) begin
            state_d = ST_IDLE;
            level_d = 1'b0;
            done_d  = 1'b1;
          end else if (cnt_q == '0) begin
            level_d = ~level_q;
            cnt_d   = RELOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= MODE_TOGGLE;
      level_q  <= 1'b0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= select_mode;
      level_q  <= level_d;
      toggle_q <= toggle_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pulse_shaper.sv
// Directed bench for pulse_shaper: a vector table on a HOLD_CYCLES=4 instance plus hand sequences
// for blink (HOLD_CYCLES=2), the HOLD_CYCLES=1 boundary and asynchronous reset mid-window.
module tb_pulse_shaper;

  logic       clk = 1'b0;
  logic       rst;
  logic       p4, p2, p1;
  logic [1:0] m4, m2, m1;
  logic       l4, b4, d4, l2, b2, d2, l1, b1, d1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_shaper #(.HOLD_CYCLES(4), .CNT_W(20)) u4 (
    .clk(clk), .rst(rst), .pulse_in(p4), .select_mode(m4),
    .level_out(l4), .busy(b4), .done(d4)
  );
  pulse_shaper #(.HOLD_CYCLES(2), .CNT_W(20)) u2 (
    .clk(clk), .rst(rst), .pulse_in(p2), .select_mode(m2),
    .level_out(l2), .busy(b2), .done(d2)
  );
  pulse_shaper #(.HOLD_CYCLES(1), .CNT_W(20)) u1 (
    .clk(clk), .rst(rst), .pulse_in(p1), .select_mode(m1),
    .level_out(l1), .busy(b1), .done(d1)
  );

  // Expected outputs are packed as {level_out, busy, done}.
  typedef struct {
    logic       pulse;
    logic [1:0] mode;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {level,busy,done}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic p, input logic [1:0] m, input logic [2:0] e);
    vec_t v;
    v.pulse = p;
    v.mode  = m;
    v.exp   = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [8:0] blink_pat;
    rst = 1'b0;
    p4 = 1'b0; p2 = 1'b0; p1 = 1'b0;
    m4 = 2'b00; m2 = 2'b00; m1 = 2'b00;
    #22;
    check("reset_u4", {l4, b4, d4}, 3'b000);
    check("reset_u2", {l2, b2, d2}, 3'b000);
    check("reset_u1", {l1, b1, d1}, 3'b000);
    rst = 1'b1;
    step();

`ifdef PULSE_SHAPER_SYNC_EN
    // Held-high async input in toggle mode: exactly one toggle, three cycles after the rise.
    p4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("sync_hold_%0d", i), {l4, b4, d4}, (i >= 2) ? 3'b100 : 3'b000);
    end
    p4 = 1'b0;
`else
    // Toggle mode: single events, then back-to-back events.
    add(1, 2'b00, 3'b100);
    add(0, 2'b00, 3'b100);
    add(1, 2'b00, 3'b000);
    add(0, 2'b00, 3'b000);
    add(1, 2'b00, 3'b100);
    add(1, 2'b00, 3'b000);
    add(1, 2'b00, 3'b100);
    // Switch to one-shot while level is high; coincident event discarded, no done.
    add(1, 2'b01, 3'b000);
    add(0, 2'b01, 3'b000);
    // One-shot: extra events mid-window and on the final cycle are ignored.
    add(1, 2'b01, 3'b110);
    add(0, 2'b01, 3'b110);
    add(1, 2'b01, 3'b110);
    add(1, 2'b01, 3'b110);
    add(1, 2'b01, 3'b001);
    add(0, 2'b01, 3'b000);
    // Retriggerable: events at offsets 0 and 3 stretch the window to 7 cycles.
    add(0, 2'b10, 3'b000);
    add(1, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(1, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b001);
    add(0, 2'b10, 3'b000);
    // Retriggerable: event on the final cycle reloads instead of ending.
    add(1, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(1, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b110);
    add(0, 2'b10, 3'b001);
    add(0, 2'b10, 3'b000);
    // Mode change during HOLD aborts silently.
    add(1, 2'b10, 3'b110);
    add(1, 2'b11, 3'b000);
    add(0, 2'b11, 3'b000);
    add(0, 2'b01, 3'b000);

    foreach (vecs[i]) begin
      p4 = vecs[i].pulse;
      m4 = vecs[i].mode;
      step();
      check($sformatf("vec_%0d", i), {l4, b4, d4}, vecs[i].exp);
    end
    p4 = 1'b0;

    // Blink, HOLD_CYCLES=2: full-length first phase, 50% duty, stop event ends with done.
    m2 = 2'b11;
    step();
    step();
    blink_pat = 9'b110011001;
    p2 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      p2 = 1'b0;
      check($sformatf("blink_%0d", i), {l2, b2, d2}, {blink_pat[8-i], 1'b1, 1'b0});
    end
    p2 = 1'b1;
    step();
    p2 = 1'b0;
    check("blink_stop", {l2, b2, d2}, 3'b001);
    step();
    check("blink_after", {l2, b2, d2}, 3'b000);

    // HOLD_CYCLES=1: one cycle high, done in the following cycle.
    m1 = 2'b01;
    step();
    p1 = 1'b1;
    step();
    p1 = 1'b0;
    check("h1_high", {l1, b1, d1}, 3'b110);
    step();
    check("h1_done", {l1, b1, d1}, 3'b001);
    step();
    check("h1_idle", {l1, b1, d1}, 3'b000);

    // Asynchronous reset in the middle of a one-shot window.
    p4 = 1'b1;
    step();
    p4 = 1'b0;
    step();
    check("pre_reset", {l4, b4, d4}, 3'b110);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", {l4, b4, d4}, 3'b000);
    #3;
    rst = 1'b1;
    step();
    step();
    check("post_reset_mode", {l4, b4, d4}, 3'b000);
    p4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      p4 = 1'b0;
      check($sformatf("fresh_win_%0d", i), {l4, b4, d4}, 3'b110);
    end
    step();
    check("fresh_done", {l4, b4, d4}, 3'b001);
    step();
    check("fresh_idle", {l4, b4, d4}, 3'b000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
